// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with burst locking and a single registered output slot.
// Optional per-requester accepted-beat counters are enabled by STREAM_RR_ARBITER_STATS_EN.
//
// state | meaning
// ARB   | pick the first valid requester after last_grant (wrapping)
// LOCK  | keep serving last_grant until it drops valid or the burst is used up
module stream_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int BURST_LEN    = 4,
  parameter int PAYLOAD_BITS = 32,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   d_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              rdy_req,
  output logic [DATA_WIDTH-1:0]           d_out,
  output logic                            vld_out,
  input  logic                            rdy_out,
  input  logic                            is_done_mode_user,
  output logic [NUM_REQ*PAYLOAD_BITS-1:0] grant_cnt,
  output logic [IDX_W-1:0]                last_grant
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [4:0] BURST_LEN_C = 5'(BURST_LEN);

  state_t           state, state_nxt;
  logic [4:0]       beat_cnt, beat_cnt_nxt;
  logic [IDX_W-1:0] last_grant_nxt;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  logic [IDX_W-1:0] sel;
  logic             sel_vld;
  logic             slot_free;
  logic             accept;

  always_comb begin
    int cand;
    cand   = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!rr_hit && vld_req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(cand);
      end
    end
  end

  // rdy_req must read zero while reset is held, even though the slot looks free.
  always_comb begin
    slot_free      = !vld_out || rdy_out;
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    last_grant_nxt = last_grant;
    sel            = '0;
    sel_vld        = 1'b0;
    rdy_req        = '0;
    accept         = 1'b0;

    if (slot_free && rst_n) begin
      case (state)
        ARB: begin
          if (rr_hit) begin
            sel     = rr_idx;
            sel_vld = 1'b1;
          end
        end
        LOCK: begin
          if (beat_cnt >= BURST_LEN_C) begin
            state_nxt = ARB;
          end else begin
            sel     = last_grant;
            sel_vld = 1'b1;
            if (!vld_req[last_grant]) state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end

    rdy_req[sel] = sel_vld;
    accept       = sel_vld && vld_req[sel];

    if (accept) begin
      last_grant_nxt = sel;
      if (state == ARB) begin
        beat_cnt_nxt = 5'd1;
        state_nxt    = (BURST_LEN > 1) ? LOCK : ARB;
      end else begin
        beat_cnt_nxt = beat_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      beat_cnt   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      vld_out    <= 1'b0;
      d_out      <= '0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_grant <= last_grant_nxt;
      if (slot_free) begin
        vld_out <= accept;
        if (accept) d_out <= d_req[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef STREAM_RR_ARBITER_STATS_EN
  logic [PAYLOAD_BITS-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (accept && !is_done_mode_user) begin
      cnt_q[sel] <= cnt_q[sel] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*PAYLOAD_BITS +: PAYLOAD_BITS] = cnt_q[g];
  end
`else
  logic stats_unused;
  assign stats_unused = is_done_mode_user;
  assign grant_cnt    = '0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic against a rule-level model.
// A second instance with BURST_LEN=1 covers the plain round-robin order.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int PB = 16;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] d_req;
  logic [N-1:0]    vld_req;
  logic [N-1:0]    rdy_req;
  logic [DW-1:0]   d_out;
  logic            vld_out;
  logic            rdy_out;
  logic            is_done_mode_user;
  logic [N*PB-1:0] grant_cnt;
  logic [1:0]      last_grant;

  logic [N*DW-1:0] b1_d;
  logic [N-1:0]    b1_vld;
  logic [N-1:0]    b1_rdy;
  logic [DW-1:0]   b1_dout;
  logic            b1_vout;
  logic            b1_rdy_out;
  logic [N*PB-1:0] b1_cnt;
  logic [1:0]      b1_last;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .d_req(d_req), .vld_req(vld_req), .rdy_req(rdy_req),
    .d_out(d_out), .vld_out(vld_out), .rdy_out(rdy_out),
    .is_done_mode_user(is_done_mode_user), .grant_cnt(grant_cnt), .last_grant(last_grant)
  );

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(1), .PAYLOAD_BITS(PB)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .d_req(b1_d), .vld_req(b1_vld), .rdy_req(b1_rdy),
    .d_out(b1_dout), .vld_out(b1_vout), .rdy_out(b1_rdy_out),
    .is_done_mode_user(1'b0), .grant_cnt(b1_cnt), .last_grant(b1_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: round-robin pointer, burst ownership and beat tally as plain integers.
  int          m_last;
  int          m_beats;
  bit          m_locked;
  bit          m_vld;
  logic [31:0] m_dout;
  int          m_cnt [N];
  int          seq   [N];

  task automatic model_reset();
    m_last   = N - 1;
    m_beats  = 0;
    m_locked = 0;
    m_vld    = 0;
    m_dout   = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      seq[i]   = 0;
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {8'(i), 24'(seq[i])};
  endfunction

  // Called at a negedge; returns at the next negedge with outputs checked.
  task automatic do_cycle(input logic [N-1:0] v, input bit ro, input bit dm);
    int          sel;
    int          c;
    bit          free;
    logic [N-1:0] rdy_exp;
    logic [63:0] g_exp;
    vld_req           = v;
    rdy_out           = ro;
    is_done_mode_user = dm;
    for (int i = 0; i < N; i++) d_req[i*DW +: DW] = word_of(i);
    #1;
    free    = !m_vld || ro;
    sel     = -1;
    rdy_exp = '0;
    if (free) begin
      if (!m_locked) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (sel < 0 && v[c]) sel = c;
        end
      end else if (m_beats < BL) begin
        sel = m_last;
      end else begin
        m_locked = 0;
      end
    end
    if (sel >= 0) rdy_exp[sel] = 1'b1;
    check("rdy_req", 64'(rdy_req), 64'(rdy_exp));
    if (free) begin
      if (sel >= 0 && v[sel]) begin
        m_vld  = 1;
        m_dout = word_of(sel);
        if (m_locked) m_beats++;
        else begin
          m_beats  = 1;
          m_locked = (BL > 1);
        end
        m_last = sel;
        if (!dm) m_cnt[sel]++;
        seq[sel]++;
      end else begin
        m_vld = 0;
        if (m_locked && sel >= 0) m_locked = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    g_exp = '0;
`ifdef STREAM_RR_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) g_exp[i*PB +: PB] = PB'(m_cnt[i]);
`endif
    check("vld_out", 64'(vld_out), 64'(m_vld));
    check("d_out", 64'(d_out), 64'(m_dout));
    check("last_grant", 64'(last_grant), 64'(m_last));
    check("grant_cnt", 64'(grant_cnt), g_exp);
  endtask

  initial begin
    int guard;
    rst_n             = 1'b0;
    vld_req           = '1;
    rdy_out           = 1'b1;
    is_done_mode_user = 1'b0;
    d_req             = '0;
    b1_vld            = '0;
    b1_rdy_out        = 1'b1;
    for (int i = 0; i < N; i++) b1_d[i*DW +: DW] = 32'hB100_0000 + 32'(i);
    model_reset();

    #12;
    check("rst_vld_out", 64'(vld_out), 64'd0);
    check("rst_d_out", 64'(d_out), 64'd0);
    check("rst_rdy_req", 64'(rdy_req), 64'd0);
    check("rst_last_grant", 64'(last_grant), 64'd3);
    check("rst_grant_cnt", 64'(grant_cnt), 64'd0);

    @(negedge clk);
    rst_n  = 1'b1;
    b1_vld = '1;

    // BURST_LEN=1 instance: order 0,1,2,3,0 one per cycle from the first edge
    for (int k = 0; k < 5; k++) begin
      do_cycle(4'b0000, 1'b1, 1'b0);
      check("b1_vld_out", 64'(b1_vout), 64'd1);
      check("b1_last_grant", 64'(b1_last), 64'(k % N));
      check("b1_d_out", 64'(b1_dout), 64'(32'hB100_0000 + 32'(k % N)));
    end
    b1_vld = '0;

    for (int k = 0; k < 14; k++) do_cycle(4'b0110, 1'b1, 1'b0);

    do_cycle(4'b0000, 1'b1, 1'b0);
    do_cycle(4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) do_cycle(4'b0000, 1'b0, 1'b0);
    do_cycle(4'b0000, 1'b1, 1'b0);
    do_cycle(4'b0000, 1'b1, 1'b0);

    do_cycle(4'b1000, 1'b1, 1'b0);
    do_cycle(4'b1000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) do_cycle(4'b0001, 1'b1, 1'b0);

    for (int k = 0; k < 600; k++)
      do_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    // asynchronous reset in the middle of a burst
    do_cycle(4'b0100, 1'b1, 1'b0);
    do_cycle(4'b0100, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld_out", 64'(vld_out), 64'd0);
    check("async_rst_rdy_req", 64'(rdy_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_cycle(4'b1111, 1'b1, 1'b0);

    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (seq[2] < 10 && guard < 40) begin
      do_cycle(4'b0100, 1'b1, 1'b0);
      guard++;
    end
    guard = 0;
    while (seq[2] < 13 && guard < 40) begin
      do_cycle(4'b0100, 1'b1, 1'b1);
      guard++;
    end
`ifdef STREAM_RR_ARBITER_STATS_EN
    check("stats_frozen_cnt2", 64'(grant_cnt[2*PB +: PB]), 64'd10);
`else
    check("stats_disabled_cnt", 64'(grant_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end
endmodule
